// File: rtl/keycode_evt_pkg.sv
// Shared types and slot helpers for the keycode event tracker.
// The optional auto-repeat bit in evt_t is present only with KEYCODE_EVT_REPEAT_EN.
package keycode_evt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN_REL = 2'd1,
        SCAN_PRS = 2'd2
    } state_t;

    typedef struct packed {
`ifdef KEYCODE_EVT_REPEAT_EN
        logic       rpt;
`endif
        logic       press;
        logic [7:0] code;
    } evt_t;

    localparam logic [7:0] HID_NONE = 8'h00;
    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_D    = 8'h07;

    function automatic logic [7:0] slot_code(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    function automatic logic code_in_word(input logic [7:0] code, input logic [31:0] w);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 4; j++)
            if (slot_code(w, 2'(j)) == code) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic code_in_lower(input logic [7:0] code, input logic [31:0] w,
                                           input logic [1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < 3; j++)
            if (j < int'(idx) && slot_code(w, 2'(j)) == code) hit = 1'b1;
        return hit;
    endfunction

    // A code produces an event only for its first occurrence in 'same' and when absent from 'other'.
    function automatic logic code_is_new(input logic [7:0] code, input logic [31:0] other,
                                         input logic [31:0] same, input logic [1:0] idx);
        return (code != HID_NONE) && !code_in_word(code, other) && !code_in_lower(code, same, idx);
    endfunction

endpackage

// File: rtl/keycode_evt_if.sv
// Valid/ready event stream from the keycode tracker to the game control logic.
interface keycode_evt_if;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_press;
    logic [7:0] evt_code;
    logic       evt_repeat;

    modport master (output evt_valid, evt_press, evt_code, evt_repeat, input evt_ready);
    modport slave  (input evt_valid, evt_press, evt_code, evt_repeat, output evt_ready);
endinterface

// File: rtl/keycode_evt_fifo.sv
// Show-ahead event FIFO: head is readable the cycle after the push edge.
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module keycode_evt_fifo
    import keycode_evt_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  evt_t                        din,
    input  logic                        pop,
    output evt_t                        dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    evt_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign level   = count;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/keycode_event_tracker.sv
// Diffs successive PIO keycode words into press/release events and tracks four watched keys.
// Optional auto-repeat of a lone held key is enabled by defining KEYCODE_EVT_REPEAT_EN.
module keycode_event_tracker
    import keycode_evt_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] KEY0_CODE  = KEY_W,
    parameter logic [7:0] KEY1_CODE  = KEY_A,
    parameter logic [7:0] KEY2_CODE  = KEY_S,
    parameter logic [7:0] KEY3_CODE  = KEY_D
`ifdef KEYCODE_EVT_REPEAT_EN
   ,parameter int         REPEAT_DELAY  = 12500000,
    parameter int         REPEAT_PERIOD = 2500000
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 keycode_in,
    keycode_evt_if.master               evt,
    output logic [$clog2(FIFO_DEPTH):0] evt_level,
    output logic [3:0]                  held_mask,
    output logic                        busy
);
    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [31:0] in_q, cur, prev;
    logic        capture, push_req, full, empty;
    logic [7:0]  scan_code;
    evt_t        push_evt, head;

    keycode_evt_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   (push_evt),
        .pop   (evt.evt_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (evt_level)
    );

    assign busy          = (state != IDLE);
    assign evt.evt_valid = !empty;
    assign evt.evt_press = !empty && head.press;
    assign evt.evt_code  = empty ? HID_NONE : head.code;

`ifdef KEYCODE_EVT_REPEAT_EN
    logic [23:0] rpt_cnt, rpt_term;
    logic        rpt_first, rpt_active, rpt_hit;

    assign evt.evt_repeat = !empty && head.rpt;
    assign rpt_term   = rpt_first ? 24'(REPEAT_DELAY - 1) : 24'(REPEAT_PERIOD - 1);
    assign rpt_active = (state == IDLE) && (in_q == cur) &&
                        (cur[7:0] != HID_NONE) && (cur[31:8] == 24'h0);
    assign rpt_hit    = rpt_active && (rpt_cnt == rpt_term);

    // Counter parks at terminal while the FIFO is full so the repeat is delayed, not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (capture) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_hit) begin
            if (!full) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b0;
            end
        end else if (rpt_active) begin
            rpt_cnt <= rpt_cnt + 24'd1;
        end
    end
`else
    assign evt.evt_repeat = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        capture   = 1'b0;
        push_req  = 1'b0;
        push_evt  = '0;
        scan_code = HID_NONE;
        case (state)
            IDLE: begin
                if (in_q != cur) begin
                    capture = 1'b1;
                    idx_n   = 2'd0;
                    state_n = SCAN_REL;
                end
`ifdef KEYCODE_EVT_REPEAT_EN
                else if (rpt_hit) begin
                    push_req       = 1'b1;
                    push_evt.rpt   = 1'b1;
                    push_evt.press = 1'b1;
                    push_evt.code  = cur[7:0];
                end
`endif
            end
            SCAN_REL: begin
                scan_code      = slot_code(prev, idx);
                push_req       = code_is_new(scan_code, cur, prev, idx);
                push_evt.press = 1'b0;
                push_evt.code  = scan_code;
                if (!(push_req && full)) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = SCAN_PRS;
                end
            end
            SCAN_PRS: begin
                scan_code      = slot_code(cur, idx);
                push_req       = code_is_new(scan_code, prev, cur, idx);
                push_evt.press = 1'b1;
                push_evt.code  = scan_code;
                if (!(push_req && full)) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q      <= '0;
            cur       <= '0;
            prev      <= '0;
            held_mask <= '0;
            state     <= IDLE;
            idx       <= '0;
        end else begin
            in_q  <= keycode_in;
            state <= state_n;
            idx   <= idx_n;
            if (capture) begin
                prev      <= cur;
                cur       <= in_q;
                held_mask <= {code_in_word(KEY3_CODE, in_q), code_in_word(KEY2_CODE, in_q),
                              code_in_word(KEY1_CODE, in_q), code_in_word(KEY0_CODE, in_q)};
            end
        end
    end

endmodule

// File: tb/tb_keycode_event_tracker.sv
// Directed bench for keycode_event_tracker: a depth-8 instance for the main cases
// and a depth-2 instance for FIFO backpressure.
module tb_keycode_event_tracker;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] kc, kc2;
    logic [3:0]  level, level2;
    logic [1:0]  level_s;
    logic [3:0]  held, held2;
    logic        busy, busy2;
    int          n_cmp = 0;
    int          n_err = 0;

    keycode_evt_if ev ();
    keycode_evt_if ev2 ();

    keycode_event_tracker #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .keycode_in(kc), .evt(ev),
        .evt_level(level), .held_mask(held), .busy(busy)
    );

    keycode_event_tracker #(.FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .keycode_in(kc2), .evt(ev2),
        .evt_level(level_s), .held_mask(held2), .busy(busy2)
    );

    assign level2 = {2'b00, level_s};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic pop_expect(input string tag, input logic press, input logic [7:0] code);
        check_eq({tag, "_valid"}, 32'(ev.evt_valid), 32'd1);
        check_eq({tag, "_press"}, 32'(ev.evt_press), 32'(press));
        check_eq({tag, "_code"}, 32'(ev.evt_code), 32'(code));
        check_eq({tag, "_rep"}, 32'(ev.evt_repeat), 32'd0);
        ev.evt_ready = 1'b1;
        tick(1);
        ev.evt_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] drain_exp [4];
        int         k;
        int         n;
        drain_exp[0] = 8'h16; drain_exp[1] = 8'h1A; drain_exp[2] = 8'h04; drain_exp[3] = 8'h07;

        reset = 1'b1;
        kc = 32'h0;
        kc2 = 32'h0;
        ev.evt_ready = 1'b0;
        ev2.evt_ready = 1'b0;
        tick(2);
        check_eq("rst_valid", 32'(ev.evt_valid), 32'd0);
        check_eq("rst_press", 32'(ev.evt_press), 32'd0);
        check_eq("rst_code", 32'(ev.evt_code), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_held", 32'(held), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(1);

        // Single key: capture at E1, no release at E2, press at head after E6, idle after E9
        kc = 32'h0000001A;
        tick(2);
        check_eq("t1_busy_e1", 32'(busy), 32'd1);
        tick(1);
        check_eq("t1_norel_e2", 32'(ev.evt_valid), 32'd0);
        tick(3);
        check_eq("t1_empty_e5", 32'(ev.evt_valid), 32'd0);
        tick(1);
        check_eq("t1_valid_e6", 32'(ev.evt_valid), 32'd1);
        check_eq("t1_held", 32'(held), 32'b0001);
        tick(2);
        check_eq("t1_busy_e8", 32'(busy), 32'd1);
        tick(1);
        check_eq("t1_idle_e9", 32'(busy), 32'd0);
        check_eq("t1_level", 32'(level), 32'd1);
        pop_expect("t1_pop", 1'b1, 8'h1A);
        check_eq("t1_level0", 32'(level), 32'd0);

        // 1A -> {04,16}: release 1A, then presses in slot order (slot0=16, slot1=04)
        kc = 32'h00000416;
        tick(2);
        wait_idle("t2_idle");
        check_eq("t2_level", 32'(level), 32'd3);
        check_eq("t2_held", 32'(held), 32'b0110);
        pop_expect("t2_p0", 1'b0, 8'h1A);
        pop_expect("t2_p1", 1'b1, 8'h16);
        pop_expect("t2_p2", 1'b1, 8'h04);
        check_eq("t2_empty", 32'(ev.evt_valid), 32'd0);

        kc = 32'h0;
        tick(2);
        wait_idle("t3_clr_idle");
        pop_expect("t3_r0", 1'b0, 8'h16);
        pop_expect("t3_r1", 1'b0, 8'h04);
        check_eq("t3_held0", 32'(held), 32'd0);

        // Duplicated code yields one press only
        kc = 32'h1A1A1A00;
        tick(2);
        wait_idle("t3_idle");
        check_eq("t3_level", 32'(level), 32'd1);
        pop_expect("t3_dup", 1'b1, 8'h1A);
        kc = 32'h1A1A1A00;
        tick(3);
        check_eq("t3_rewr_busy", 32'(busy), 32'd0);
        tick(8);
        check_eq("t3_rewr_level", 32'(level), 32'd0);

        // Depth-2 FIFO backpressure: stall at press slot 2, then drain without loss
        kc2 = 32'h07041A16;
        tick(20);
        check_eq("t4_busy", 32'(busy2), 32'd1);
        check_eq("t4_level", 32'(level2), 32'd2);
        check_eq("t4_head", 32'(ev2.evt_code), 32'h16);
        ev2.evt_ready = 1'b1;
        k = 0;
        n = 0;
        while (n < 30) begin
            if (ev2.evt_valid) begin
                if (k < 4) check_eq($sformatf("t4_drain%0d", k), 32'(ev2.evt_code), 32'(drain_exp[k]));
                if (k < 4) check_eq($sformatf("t4_press%0d", k), 32'(ev2.evt_press), 32'd1);
                k++;
            end
            tick(1);
            n++;
        end
        ev2.evt_ready = 1'b0;
        check_eq("t4_count", 32'(k), 32'd4);
        check_eq("t4_idle", 32'(busy2), 32'd0);
        check_eq("t4_level0", 32'(level2), 32'd0);

        // Asynchronous reset during a scan clears outputs at once
        kc = 32'h00000004;
        tick(4);
        check_eq("t5_mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_valid", 32'(ev.evt_valid), 32'd0);
        check_eq("t5_rst_held", 32'(held), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_level", 32'(level), 32'd0);
        kc = 32'h00000007;
        tick(2);
        reset = 1'b0;
        tick(3);
        wait_idle("t5_idle");
        check_eq("t5_level", 32'(level), 32'd1);
        check_eq("t5_held", 32'(held), 32'b1000);
        pop_expect("t5_pop", 1'b1, 8'h07);
        check_eq("t5_empty", 32'(ev.evt_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
